// File: rtl/seq_mult_unit.sv
// Iterative radix-2 shift-add multiplier with valid/ready operand and product handshakes.
// Signed operands are handled as magnitudes, and the sign is applied once in FIX.

module cla4badd (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | WIDTH shift-add iterations through the cla4badd chain
// FIX   | negate the double-width register when the result is negative
// DONE  | load product, then hold out_valid until out_ready
module seq_mult_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH);
    localparam int NB = WIDTH / 4;

    if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("seq_mult_unit: WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mcand;
    logic             neg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_sum;
    logic [NB:0]        carry;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] full;
    logic [2*WIDTH-1:0] full_neg;

    // Gating the addend to zero makes the chain a pass-through with carry 0.
    assign addend   = acc_lo[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NB; i++) begin : g_cla
        cla4badd u_cla (
            .a    (acc_hi[4*i +: 4]),
            .b    (addend[4*i +: 4]),
            .cin  (carry[i]),
            .sum  (add_sum[4*i +: 4]),
            .cout (carry[i+1])
        );
    end

    // The magnitude of the most negative value still fits as an unsigned WIDTH-bit value.
    assign abs_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    assign abs_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

    assign full     = {acc_hi, acc_lo};
    assign full_neg = ~full + (2*WIDTH)'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= abs_a;
                        acc_lo   <= abs_b;
                        acc_hi   <= '0;
                        neg      <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        cnt      <= CW'(WIDTH - 1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    {acc_hi, acc_lo} <= {carry[NB], add_sum, acc_lo[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (neg) begin
                        {acc_hi, acc_lo} <= full_neg;
                    end
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle copies the result out; after that it waits for the handshake.
                    if (!out_valid) begin
                        product   <= full;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed and random checks for seq_mult_unit at WIDTH=16: latency, signed/unsigned
// products, backpressure, mid-operation reset and handshake accounting.
module tb_seq_mult_unit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int acc_cnt = 0;

    seq_mult_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_cnt++;
        if (rst_n && in_valid && in_ready) acc_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b,
                                             input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        if (s) begin
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            return sa * sb;
        end
        return {16'h0, a} * {16'h0, b};
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp, input int stall, input string tag);
        int lat;
        int hs0;
        int acc0;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_in_ready"}, in_ready, 1);
        hs0 = hs_cnt;
        @(posedge clk); #1;
        acc0 = acc_cnt;
        in_valid  = 1'b0;
        op_a      = 16'($urandom);
        op_b      = 16'($urandom);
        is_signed = 1'($urandom);
        chk({tag, "_busy_after_accept"}, busy, 1);
        chk({tag, "_ready_after_accept"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 18);
        chk({tag, "_product"}, product, exp);
        if (stall > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk({tag, "_stall_valid"}, out_valid, 1);
                chk({tag, "_stall_product"}, product, exp);
                chk({tag, "_stall_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_valid_dropped"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_product_held"}, product, exp);
        chk({tag, "_one_handshake"}, hs_cnt - hs0, 1);
        chk({tag, "_no_extra_accept"}, acc_cnt - acc0, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_product", product, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h0003, 16'h0005, 1'b0, 32'h0000000F, 0, "u_3x5");
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, "u_max");
        do_op(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 0, "s_m3x7");
        do_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0, "s_min_sq");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 0, "s_m1xm1");
        do_op(16'h0000, 16'h1234, 1'b0, 32'h00000000, 0, "u_zero");
        do_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 0, "s_min_x1");
        do_op(16'h1234, 16'h0010, 1'b0, 32'h00012340, 5, "bp");

        op_a      = 16'h00AB;
        op_b      = 16'h00CD;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_product", product, 0);
        do_op(16'h0002, 16'h0002, 1'b0, 32'h00000004, 0, "after_rst");

        for (int n = 0; n < 200; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, ref_mult(ra, rb, rs), $urandom_range(0, 3), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
